// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder: recovers pixel position, active flag and lock
// state from an incoming HS/VS sync pair on the pixel clock.
module vga_sync_decoder #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_hs,
  input  logic       i_vs,
  output logic [9:0] o_px,
  output logic [9:0] o_py,
  output logic       o_activeArea,
  output logic       o_locked,
  output logic       o_frameStart,
  output logic [7:0] o_errCount
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] CNT_MAX = 11'h7ff;
  localparam logic [10:0] H_LAST  = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST  = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_LO    = 11'(H_SYNC + H_BP);
  localparam logic [10:0] H_HI    = 11'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [10:0] V_LO    = 11'(V_SYNC + V_BP);
  localparam logic [10:0] V_HI    = 11'(V_SYNC + V_BP + V_ACTIVE);

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    ACQUIRE  = 2'd1,
    LOCKED   = 2'd2
  } state_t;

  state_t      state;
  state_t      next_state;
  logic        hs;
  logic        vs;
  logic        r_hs;
  logic        r_vs;
  logic        hs_start;
  logic        vs_start;
  logic        vpend;
  logic        vreset;
  logic        line_bad;
  logic        frame_bad;
  logic        h_sat;
  logic        err_inc;
  logic        in_win;
  logic [10:0] hcnt;
  logic [10:0] vcnt;
  logic [9:0]  px_w;
  logic [9:0]  py_w;

  assign hs       = i_hs ^ SYNC_ACTIVE_LOW;
  assign vs       = i_vs ^ SYNC_ACTIVE_LOW;
  assign hs_start = hs & ~r_hs;
  assign vs_start = vs & ~r_vs;

  // a vs edge only takes effect on a line boundary
  assign vreset    = hs_start & (vpend | vs_start);
  assign line_bad  = hs_start & (hcnt != H_LAST);
  assign frame_bad = vreset & (vcnt != V_LAST);
  assign h_sat     = (hcnt == CNT_MAX);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_hs  <= 1'b0;
      r_vs  <= 1'b0;
      hcnt  <= CNT_MAX;
      vcnt  <= CNT_MAX;
      vpend <= 1'b0;
    end else begin
      r_hs <= hs;
      r_vs <= vs;
      if (hs_start) begin
        hcnt <= '0;
      end else if (!h_sat) begin
        hcnt <= hcnt + 11'd1;
      end
      if (vreset) begin
        vcnt  <= '0;
        vpend <= 1'b0;
      end else begin
        if (vs_start) begin
          vpend <= 1'b1;
        end
        if (hs_start && vcnt != CNT_MAX) begin
          vcnt <= vcnt + 11'd1;
        end
      end
    end
  end

  // the vreset leaving UNLOCKED is not line-checked
  always_comb begin
    next_state = state;
    err_inc    = 1'b0;
    unique case (state)
      UNLOCKED: begin
        if (vreset) begin
          next_state = ACQUIRE;
        end
      end
      ACQUIRE: begin
        if (line_bad || h_sat) begin
          next_state = UNLOCKED;
        end else if (vreset && !frame_bad) begin
          next_state = LOCKED;
        end
      end
      LOCKED: begin
        if (line_bad || frame_bad || h_sat) begin
          next_state = UNLOCKED;
          err_inc    = 1'b1;
        end
      end
      default: next_state = UNLOCKED;
    endcase
  end

  assign px_w   = hcnt[9:0] - H_LO[9:0];
  assign py_w   = vcnt[9:0] - V_LO[9:0];
  assign in_win = (hcnt >= H_LO) && (hcnt < H_HI) &&
                  (vcnt >= V_LO) && (vcnt < V_HI) &&
                  (state == LOCKED);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state        <= UNLOCKED;
      o_px         <= '0;
      o_py         <= '0;
      o_activeArea <= 1'b0;
      o_locked     <= 1'b0;
      o_frameStart <= 1'b0;
      o_errCount   <= '0;
    end else begin
      state        <= next_state;
      o_activeArea <= in_win;
      o_px         <= in_win ? px_w : '0;
      o_py         <= in_win ? py_w : '0;
      o_locked     <= (state == LOCKED);
      o_frameStart <= vreset && (next_state == LOCKED);
      if (err_inc && o_errCount != 8'hff) begin
        o_errCount <= o_errCount + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// tb_vga_sync_decoder: directed checks of lock, coordinates and
// error handling on a reduced 16x9 timing.
module tb_vga_sync_decoder;

  localparam int HA = 8;
  localparam int HF = 2;
  localparam int HS = 3;
  localparam int HB = 3;
  localparam int VA = 4;
  localparam int VF = 1;
  localparam int VS = 2;
  localparam int VB = 2;
  localparam int HT = 16;
  localparam int VT = 9;
  localparam int FRAME = 144;

  logic       i_clk = 1'b0;
  logic       i_reset_n = 1'b1;
  logic       i_hs = 1'b1;
  logic       i_vs = 1'b1;
  logic [9:0] o_px;
  logic [9:0] o_py;
  logic       o_activeArea;
  logic       o_locked;
  logic       o_frameStart;
  logic [7:0] o_errCount;

  int n_pass = 0;
  int n_total = 0;
  int gh = 0;
  int gv = 0;
  int dh = 0;
  int dv = 0;
  int cur_len = HT;
  int cur_vlen = VT;
  int vs_early = 0;

  vga_sync_decoder #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_ACTIVE_LOW(1'b1)
  ) dut (
    .i_clk(i_clk),
    .i_reset_n(i_reset_n),
    .i_hs(i_hs),
    .i_vs(i_vs),
    .o_px(o_px),
    .o_py(o_py),
    .o_activeArea(o_activeArea),
    .o_locked(o_locked),
    .o_frameStart(o_frameStart),
    .o_errCount(o_errCount)
  );

  always #5 i_clk = ~i_clk;

  // inputs change at negedge; outputs are read 1 after the posedge
  task automatic drive(input logic hs_a, input logic vs_a);
    @(negedge i_clk);
    i_hs = ~hs_a;
    i_vs = ~vs_a;
    @(posedge i_clk);
    #1;
  endtask

  task automatic gen_clk();
    logic hs_a;
    logic vs_a;
    hs_a = (gh < HS);
    vs_a = (gv < VS) ||
           (vs_early > 0 && gv == cur_vlen - 1 && gh >= vs_early);
    dh = gh;
    dv = gv;
    drive(hs_a, vs_a);
    gh++;
    if (gh >= cur_len) begin
      gh = 0;
      cur_len = HT;
      gv++;
      if (gv >= cur_vlen) begin
        gv = 0;
        cur_vlen = VT;
      end
    end
  endtask

  task automatic run_to(input int v, input int h, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3 * FRAME; i++) begin
      gen_clk();
      if (dv == v && dh == h) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    logic [30:0] got;
    #2 i_reset_n = 1'b0;
    #1;
    got = {o_px, o_py, o_activeArea, o_locked, o_frameStart, o_errCount};
    n_total++;
    if (got !== 31'h0)
      $display("FAIL reset_async: got %h expected 0", got);
    else n_pass++;
    repeat (3) @(posedge i_clk);
    #1;
    got = {o_px, o_py, o_activeArea, o_locked, o_frameStart, o_errCount};
    n_total++;
    if (got !== 31'h0)
      $display("FAIL reset_hold: got %h expected 0", got);
    else n_pass++;
    @(negedge i_clk);
    i_reset_n = 1'b1;
  endtask

  task automatic test_nominal_lock();
    int found;
    logic seen;
    gh = 0;
    gv = 0;
    cur_len = HT;
    cur_vlen = VT;
    vs_early = 0;
    seen = 1'b0;
    for (int i = 0; i < FRAME; i++) begin
      gen_clk();
      seen = seen | o_locked | o_frameStart;
    end
    n_total++;
    if (seen !== 1'b0)
      $display("FAIL acq_frame: locked/fs seen %b expected 0", seen);
    else n_pass++;
    gen_clk();
    n_total++;
    if ({o_locked, o_frameStart} !== 2'b01)
      $display("FAIL lock_vreset: {locked,fs}=%b expected 01",
               {o_locked, o_frameStart});
    else n_pass++;
    gen_clk();
    n_total++;
    if ({o_locked, o_frameStart} !== 2'b10)
      $display("FAIL lock_rise: {locked,fs}=%b expected 10",
               {o_locked, o_frameStart});
    else n_pass++;
    n_total++;
    if (o_errCount !== 8'd0)
      $display("FAIL lock_err: got %0d expected 0", o_errCount);
    else n_pass++;
    found = -1;
    for (int i = FRAME + 2; i <= 3 * FRAME; i++) begin
      gen_clk();
      if (o_frameStart === 1'b1) begin
        found = i;
        break;
      end
    end
    n_total++;
    if (found != 2 * FRAME)
      $display("FAIL fs_period: pulse at %0d expected %0d",
               found, 2 * FRAME);
    else n_pass++;
  endtask

  task automatic test_coords();
    int ph;
    int pv;
    logic [20:0] want;
    logic [20:0] got;
    for (int i = 0; i < 2 * FRAME; i++) begin
      ph = dh;
      pv = dv;
      gen_clk();
      if (ph >= HS + HB && ph < HS + HB + HA &&
          pv >= VS + VB && pv < VS + VB + VA)
        want = {1'b1, 10'(ph - HS - HB), 10'(pv - VS - VB)};
      else
        want = '0;
      got = {o_activeArea, o_px, o_py};
      n_total++;
      if (got !== want)
        $display("FAIL coord h%0d v%0d: {act,px,py}=%h expected %h",
                 ph, pv, got, want);
      else n_pass++;
    end
  endtask

  task automatic test_vs_align();
    int modes[2];
    int pulses;
    bit found;
    modes[0] = 5;
    modes[1] = 0;
    for (int m = 0; m < 2; m++) begin
      vs_early = modes[m];
      pulses = 0;
      found = 1'b0;
      for (int i = 0; i < 2 * FRAME; i++) begin
        gen_clk();
        if (dh == 0 && dv == 0) begin
          found = 1'b1;
          break;
        end
        pulses += int'(o_frameStart);
      end
      n_total++;
      if ({found, o_frameStart, o_locked} !== 3'b111 || pulses != 0)
        $display("FAIL vs_align_%0d: {found,fs,locked}=%b early=%0d expected 111/0",
                 modes[m], {found, o_frameStart, o_locked}, pulses);
      else n_pass++;
      n_total++;
      if (o_errCount !== 8'd0)
        $display("FAIL vs_align_err_%0d: got %0d expected 0",
                 modes[m], o_errCount);
      else n_pass++;
    end
    vs_early = 0;
  endtask

  task automatic test_short_line();
    bit ok;
    bit ok2;
    run_to(5, 0, ok);
    cur_len = HT - 1;
    run_to(6, 0, ok2);
    n_total++;
    if ({ok, ok2, o_locked, o_errCount} !== {3'b111, 8'd1})
      $display("FAIL short_err: {ok,ok,locked}=%b err=%0d expected 111/1",
               {ok, ok2, o_locked}, o_errCount);
    else n_pass++;
    gen_clk();
    n_total++;
    if (o_locked !== 1'b0)
      $display("FAIL short_drop: locked=%b expected 0", o_locked);
    else n_pass++;
    run_to(0, 0, ok);
    n_total++;
    if ({ok, o_locked, o_frameStart} !== 3'b100)
      $display("FAIL short_acq: {ok,locked,fs}=%b expected 100",
               {ok, o_locked, o_frameStart});
    else n_pass++;
    run_to(0, 0, ok);
    n_total++;
    if ({ok, o_locked, o_frameStart} !== 3'b101)
      $display("FAIL short_relock_fs: {ok,locked,fs}=%b expected 101",
               {ok, o_locked, o_frameStart});
    else n_pass++;
    gen_clk();
    n_total++;
    if ({o_locked, o_errCount} !== {1'b1, 8'd1})
      $display("FAIL short_relock: locked=%b err=%0d expected 1/1",
               o_locked, o_errCount);
    else n_pass++;
  endtask

  task automatic test_long_frame();
    bit ok;
    bit ok2;
    run_to(0, 0, ok);
    cur_vlen = VT + 1;
    run_to(0, 0, ok2);
    n_total++;
    if ({ok, ok2, o_locked, o_frameStart, o_errCount} !==
        {4'b1110, 8'd2})
      $display("FAIL long_err: {ok,ok,locked,fs}=%b err=%0d expected 1110/2",
               {ok, ok2, o_locked, o_frameStart}, o_errCount);
    else n_pass++;
    gen_clk();
    n_total++;
    if (o_locked !== 1'b0)
      $display("FAIL long_drop: locked=%b expected 0", o_locked);
    else n_pass++;
    run_to(0, 0, ok);
    run_to(0, 0, ok2);
    n_total++;
    if ({ok, ok2, o_frameStart} !== 3'b111)
      $display("FAIL long_relock_fs: {ok,ok,fs}=%b expected 111",
               {ok, ok2, o_frameStart});
    else n_pass++;
    gen_clk();
    n_total++;
    if ({o_locked, o_errCount} !== {1'b1, 8'd2})
      $display("FAIL long_relock: locked=%b err=%0d expected 1/2",
               o_locked, o_errCount);
    else n_pass++;
  endtask

  task automatic test_hs_loss();
    bit ok;
    logic act_seen;
    run_to(0, 0, ok);
    n_total++;
    if ({ok, o_locked} !== 2'b11)
      $display("FAIL loss_pre: {ok,locked}=%b expected 11", {ok, o_locked});
    else n_pass++;
    act_seen = 1'b0;
    for (int k = 1; k <= 2100; k++) begin
      drive(1'b0, 1'b0);
      if (k == 2047) begin
        n_total++;
        if ({o_locked, o_errCount} !== {1'b1, 8'd2})
          $display("FAIL loss_2047: locked=%b err=%0d expected 1/2",
                   o_locked, o_errCount);
        else n_pass++;
      end
      if (k == 2048) begin
        n_total++;
        if ({o_locked, o_errCount} !== {1'b1, 8'd3})
          $display("FAIL loss_2048: locked=%b err=%0d expected 1/3",
                   o_locked, o_errCount);
        else n_pass++;
      end
      if (k == 2049) begin
        n_total++;
        if (o_locked !== 1'b0)
          $display("FAIL loss_2049: locked=%b expected 0", o_locked);
        else n_pass++;
      end
      if (k >= 2049) act_seen = act_seen | o_activeArea;
    end
    n_total++;
    if ({act_seen, o_locked, o_px, o_py} !== 22'h0)
      $display("FAIL loss_after: {act,locked,px,py}=%h expected 0",
               {act_seen, o_locked, o_px, o_py});
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    bit ok;
    bit ok2;
    logic [30:0] got;
    gh = 0;
    gv = 0;
    cur_len = HT;
    cur_vlen = VT;
    gen_clk();
    run_to(0, 0, ok);
    gen_clk();
    n_total++;
    if ({ok, o_locked, o_errCount} !== {2'b11, 8'd3})
      $display("FAIL mid_prelock: {ok,locked}=%b err=%0d expected 11/3",
               {ok, o_locked}, o_errCount);
    else n_pass++;
    run_to(5, 8, ok2);
    n_total++;
    if ({ok2, o_activeArea, o_px, o_py} !== {2'b11, 10'd1, 10'd1})
      $display("FAIL mid_active: {ok,act,px,py}=%h expected %h",
               {ok2, o_activeArea, o_px, o_py}, {2'b11, 10'd1, 10'd1});
    else n_pass++;
    i_reset_n = 1'b0;
    #1;
    got = {o_px, o_py, o_activeArea, o_locked, o_frameStart, o_errCount};
    n_total++;
    if (got !== 31'h0)
      $display("FAIL mid_reset_async: got %h expected 0", got);
    else n_pass++;
    i_hs = 1'b1;
    i_vs = 1'b1;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    i_reset_n = 1'b1;
    #1;
    got = {o_px, o_py, o_activeArea, o_locked, o_frameStart, o_errCount};
    n_total++;
    if (got !== 31'h0)
      $display("FAIL mid_reset_release: got %h expected 0", got);
    else n_pass++;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: run did not end, %0d/%0d so far",
             n_pass, n_total);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_nominal_lock();
    test_coords();
    test_vs_align();
    test_short_line();
    test_long_frame();
    test_hs_loss();
    test_reset_mid();
    test_nominal_lock();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/vga_sync_decoder.md
# vga_sync_decoder

Receive-side counterpart of the VGA sync generator: consumes HS/VS sync pulses and recovers pixel coordinates, active-area flag and a lock indication. Verifies line and frame lengths against the configured 640x480@60 timing and only reports positions once a full, correctly timed frame has been seen. It sits on the same 25 MHz pixel clock as the generator. It is used for loopback self-checking and for driving pixel-consuming logic from an external sync source.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal porch and sync widths in clocks
- V_ACTIVE, 480, visible lines per frame
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical porch and sync widths in lines
- SYNC_ACTIVE_LOW, 1, 1 = HS/VS asserted low, 0 = asserted high
- Derived: H_TOTAL = 800, V_TOTAL = 525.

Ports:
- i_clk  in  1  pixel clock, rising edge
- i_reset_n  in  1  asynchronous, active-low reset; one clock, async active-low
- i_hs  in  1  horizontal sync, same clock domain
- i_vs  in  1  vertical sync, same clock domain
- o_px  out  10  recovered column; 0 outside active area
- o_py  out  10  recovered row; 0 outside active area
- o_activeArea  out  1  high while a visible pixel is being received and locked
- o_locked  out  1  timing verified
- o_frameStart  out  1  one-cycle pulse at each vertical reset while locked
- o_errCount  out  8  lock losses from LOCKED; saturates at 255

## Operation
- **Sync normalisation.** hs = i_hs XOR SYNC_ACTIVE_LOW, and likewise for vs. r_hs and r_vs hold the previous sample. hs_start = hs & !r_hs. vs_start = vs & !r_vs.
- **hcnt (11 bit).**
  - On hs_start, hcnt <= 0.
  - Otherwise hcnt increments and saturates at 2047.
  - Line check at hs_start: line_ok = (hcnt + 1 == H_TOTAL).
- **vcnt (11 bit).**
  - vs_start sets vpend.
  - On hs_start with (vpend | vs_start): vcnt <= 0, vpend <= 0, and a vertical reset event occurs.
  - Other hs_start: vcnt increments, saturating at 2047.
  - Frame check at a vertical reset: frame_ok = (vcnt + 1 == V_TOTAL).
- **Lock FSM (UNLOCKED, ACQUIRE, LOCKED).**
  - UNLOCKED: at the first vertical reset, go to ACQUIRE.
  - ACQUIRE: a bad line check or hcnt == 2047 goes to UNLOCKED. The next vertical reset goes to LOCKED if frame_ok, otherwise stays in ACQUIRE (restarting the count).
  - LOCKED: a bad line, a bad frame, or hcnt == 2047 goes to UNLOCKED and increments o_errCount.
  - The first hs_start after any vertical reset is the reset itself and is not line-checked in UNLOCKED.
- **Active window.** hcnt in [H_SYNC+H_BP, H_SYNC+H_BP+H_ACTIVE) and vcnt in [V_SYNC+V_BP, V_SYNC+V_BP+V_ACTIVE) and state == LOCKED.
- **Coordinates.** o_px = hcnt − (H_SYNC+H_BP) and o_py = vcnt − (V_SYNC+V_BP), truncated to 10 bits, only inside the window.

## Timing
- **Reset.** State UNLOCKED, hcnt = 2047, vcnt = 2047, vpend = 0, r_hs = r_vs = 0 (deasserted). All outputs are 0.
- **Reset mid-frame.** Same values; re-lock needs a full vertical reset followed by one good frame.
- **Register stages.** All outputs are registered; hcnt = k after edge T+k, where T is the first edge sampling hs asserted.
- **Active-area timing.** For a line in the window, o_activeArea first rises after edge T+H_SYNC+H_BP+1 with o_px = 0. The last active cycle carries o_px = 639.
- **o_locked.** Rises after the edge following the vertical reset that completes the first good frame. Falls after the edge following the failing check.
- **o_frameStart.** High for exactly the cycle after a vertical reset while the FSM is LOCKED, including the transition into LOCKED.
- **vs edge position.** If vs_start coincides with hs_start, the vertical reset happens at that edge. A vs edge mid-line takes effect at the next hs_start.
- **Saturation.** hcnt reaching 2047 (no HS for more than 2047 clocks) forces UNLOCKED.

## Test plan
- **Nominal lock.** Loop back the sync generator outputs after reset. o_locked rises exactly one full frame (525×800 clocks) after the first vertical reset. o_errCount stays 0. o_frameStart pulses every 420000 clocks.
- **Coordinate check.** When locked, compare against the generator's px/py/activeArea delayed to match the decoder's register stages. They must match on every cycle for 3 frames, including o_px = 639 and o_py = 479 at the last pixel.
- **Short line.** One line is 799 clocks while LOCKED. o_locked falls after the next edge, o_errCount = 1, and re-lock happens after the following vertical reset plus one frame.
- **HS loss.** Hold i_hs deasserted for 2100 clocks while locked. o_locked drops when hcnt hits 2047, and o_activeArea = 0 thereafter.
- **VS alignment.** Assert vs 100 clocks into a line versus aligned with the hs edge. The vertical reset occurs at the next or the same hs_start respectively, and the frame length check passes in both cases.
- **Reset mid-frame.** Assert i_reset_n low for 3 clocks mid-active while locked. All outputs are 0 immediately (asynchronously), o_errCount = 0, and lock reacquires exactly as in the nominal lock scenario.
